// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and defaults for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    localparam int DATAWIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
import mips_muldiv_pkg::*;

module mips_muldiv_step #(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 div_mode,
    input  logic [DATAWIDTH-1:0] p_in,
    input  logic [DATAWIDTH-1:0] q_in,
    input  logic [DATAWIDTH-1:0] b_in,
    output logic [DATAWIDTH-1:0] p_next,
    output logic [DATAWIDTH-1:0] q_next,
    output logic                 q_bit
);

    logic [DATAWIDTH-1:0] addend;
    logic [DATAWIDTH:0]   sum;
    logic [DATAWIDTH:0]   shifted;
    logic [DATAWIDTH-1:0] diff;

    always_comb begin
        addend  = q_in[0] ? b_in : '0;
        sum     = {1'b0, p_in} + {1'b0, addend};
        shifted = {p_in, q_in[DATAWIDTH-1]};
        // The true difference is below b_in whenever it is kept, so DATAWIDTH bits suffice.
        diff    = shifted[DATAWIDTH-1:0] - b_in;
        if (div_mode) begin
            q_bit  = (shifted >= {1'b0, b_in});
            p_next = q_bit ? diff : shifted[DATAWIDTH-1:0];
            q_next = {q_in[DATAWIDTH-2:0], q_bit};
        end else begin
            q_bit  = 1'b0;
            p_next = sum[DATAWIDTH:1];
            q_next = {sum[0], q_in[DATAWIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit; MADD/MADDU accumulate enabled by MIPS_MULDIV_MADD_EN.
import mips_muldiv_pkg::*;

module mips_muldiv #(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           op,
    input  logic [DATAWIDTH-1:0] A_in,
    input  logic [DATAWIDTH-1:0] B_in,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] HI,
    output logic [DATAWIDTH-1:0] LO
);

    function automatic logic [DATAWIDTH-1:0] mag(input logic is_signed,
                                                 input logic signed [DATAWIDTH-1:0] v);
        return (is_signed && v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATAWIDTH-1:0] neg_if(input logic n, input logic [DATAWIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*DATAWIDTH-1:0] neg2_if(input logic n,
                                                       input logic [2*DATAWIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] p_q, p_d, q_q, q_d, b_q, b_d;
    logic [DATAWIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic                 div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic                 done_q, done_d;
`ifdef MIPS_MULDIV_MADD_EN
    logic                 acc_q, acc_d;
`endif

    op_e                  op_c;
    logic                 accept, is_signed, is_div, is_iter, sa, sb;
    logic [DATAWIDTH-1:0] step_p, step_q;
    logic                 step_qbit;
    logic [2*DATAWIDTH-1:0] prod;

    assign op_c        = op_e'(op);
    assign start_ready = (state_q == ST_IDLE) & ~flush;
    assign accept      = start_valid & start_ready & ~flush;
    assign busy        = (state_q == ST_CALC) | (state_q == ST_FIX);
    assign done        = done_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

    assign is_signed = (op_c == OP_MULT) | (op_c == OP_DIV) | (op_c == OP_MADD);
    assign is_div    = (op_c == OP_DIV) | (op_c == OP_DIVU);
`ifdef MIPS_MULDIV_MADD_EN
    assign is_iter   = (op_c != OP_MTHI) & (op_c != OP_MTLO);
`else
    assign is_iter   = (op_c == OP_MULT) | (op_c == OP_MULTU) | is_div;
`endif
    assign sa = is_signed & A_in[DATAWIDTH-1];
    assign sb = is_signed & B_in[DATAWIDTH-1];

    mips_muldiv_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .div_mode (div_q),
        .p_in     (p_q),
        .q_in     (q_q),
        .b_in     (b_q),
        .p_next   (step_p),
        .q_next   (step_q),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
        acc_d   = acc_q;
`endif
        prod    = neg2_if(neg_q, {p_q, q_q});
`ifdef MIPS_MULDIV_MADD_EN
        if (acc_q) prod = prod + {hi_q, lo_q};
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_c == OP_MTHI) begin
                        hi_d   = A_in;
                        done_d = 1'b1;
                    end else if (op_c == OP_MTLO) begin
                        lo_d   = A_in;
                        done_d = 1'b1;
                    end else if (is_iter) begin
                        p_d     = '0;
                        q_d     = mag(is_signed, A_in);
                        b_d     = mag(is_signed, B_in);
                        div_d   = is_div;
                        neg_d   = sa ^ sb;
                        rneg_d  = sa;
                        dz_d    = is_div & (B_in == '0);
`ifdef MIPS_MULDIV_MADD_EN
                        acc_d   = (op_c == OP_MADD) | (op_c == OP_MADDU);
`endif
                        cnt_d   = CNTW'(DATAWIDTH);
                        state_d = ST_CALC;
                    end else begin
                        // Accumulate ops without the accumulator complete as a no-op.
                        done_d = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    p_d   = step_p;
                    q_d   = div_q ? {q_q[DATAWIDTH-2:0], step_qbit} : step_q;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        // Divide by zero leaves quotient all ones; remainder reconstructs the dividend.
                        lo_d = dz_q ? '1 : neg_if(neg_q, q_q);
                        hi_d = neg_if(rneg_q, p_q);
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
`ifdef MIPS_MULDIV_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

endmodule
